// File: rtl/control_if.sv
// Control-unit bundle: decode-stage opcode and pipeline controls in, registered
// per-stage control fields out.
interface control_if;
  logic [5:0] opCode;
  logic       stall;
  logic       flush;
  logic [1:0] writeBackControl;
  logic [1:0] memAccessControl;
  logic [3:0] calculationControl;
  logic       illegalOp;

  modport master (
    output opCode, stall, flush,
    input  writeBackControl, memAccessControl, calculationControl, illegalOp
  );

  modport slave (
    input  opCode, stall, flush,
    output writeBackControl, memAccessControl, calculationControl, illegalOp
  );
endinterface

// File: rtl/control.sv
// Main control unit: decodes the opcode into per-stage control fields.
// All outputs are registered, with priority rst > flush > stall > decode.
module control (
  input  logic     clk,
  input  logic     rst,
  control_if.slave ctrl
);

  logic [1:0] writeBackReg, writeBackNext;
  logic [1:0] memAccessReg, memAccessNext;
  logic [3:0] calculationReg, calculationNext;
  logic       illegalReg, illegalNext;

  // Field order: WB = {RegWrite, MemToReg}, MEM = {MemRead, MemWrite},
  // CALC = {RegDst, ALUOp[1:0], ALUSrc}.
  always_comb begin
    writeBackNext   = 2'b00;
    memAccessNext   = 2'b00;
    calculationNext = 4'b0000;
    illegalNext     = 1'b0;
    case (ctrl.opCode)
      6'd0: begin
        writeBackNext   = 2'b10;
        calculationNext = 4'b1100;
      end
      6'd1: begin
        writeBackNext   = 2'b11;
        memAccessNext   = 2'b10;
        calculationNext = 4'b0001;
      end
      6'd2: begin
        memAccessNext   = 2'b01;
        calculationNext = 4'b0001;
      end
      6'd3: begin
        calculationNext = 4'b0010;
      end
      6'd4: begin
        writeBackNext   = 2'b10;
        calculationNext = 4'b0001;
      end
      6'd5: begin
        writeBackNext   = 2'b10;
        calculationNext = 4'b0111;
      end
      // Undefined opcodes raise illegalOp but otherwise behave as a bubble.
      default: begin
        illegalNext     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || ctrl.flush) begin
      writeBackReg   <= 2'b00;
      memAccessReg   <= 2'b00;
      calculationReg <= 4'b0000;
      illegalReg     <= 1'b0;
    end else if (!ctrl.stall) begin
      writeBackReg   <= writeBackNext;
      memAccessReg   <= memAccessNext;
      calculationReg <= calculationNext;
      illegalReg     <= illegalNext;
    end
  end

  assign ctrl.writeBackControl   = writeBackReg;
  assign ctrl.memAccessControl   = memAccessReg;
  assign ctrl.calculationControl = calculationReg;
  assign ctrl.illegalOp          = illegalReg;

endmodule

// File: tb/tb_control.sv
// Directed and sweep checks for the control unit; outputs are packed as
// {WB[1:0], MEM[1:0], CALC[3:0], illegalOp}.
module tb_control;

  logic clk;
  logic rst;
  control_if ctrl ();

  control dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errorCount = 0;
  int checkCount = 0;

  task automatic check(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("FAIL %s: got %b want %b", tag, observed, expected);
    end else begin
      $display("check %s: %b ok", tag, observed);
    end
  endtask

  function automatic logic [8:0] observedVec();
    return {ctrl.writeBackControl, ctrl.memAccessControl,
            ctrl.calculationControl, ctrl.illegalOp};
  endfunction

  // Reference decode table, written out independently of the RTL.
  function automatic logic [8:0] decodeRef(input logic [5:0] op);
    logic [8:0] r;
    case (op)
      6'd0:    r = 9'b10_00_1100_0;
      6'd1:    r = 9'b11_10_0001_0;
      6'd2:    r = 9'b00_01_0001_0;
      6'd3:    r = 9'b00_00_0010_0;
      6'd4:    r = 9'b10_00_0001_0;
      6'd5:    r = 9'b10_00_0111_0;
      default: r = 9'b00_00_0000_1;
    endcase
    return r;
  endfunction

  // Drive one cycle of inputs, advance past the edge, compare with expected.
  task automatic apply(input string tag, input logic [5:0] op, input logic st,
                       input logic fl, input logic r, input logic [8:0] expected);
    ctrl.opCode = op;
    ctrl.stall  = st;
    ctrl.flush  = fl;
    rst         = r;
    @(posedge clk);
    #1;
    check(tag, observedVec(), expected);
  endtask

  logic [8:0] model;
  logic [8:0] obs;
  logic       st, fl;

  initial begin
    ctrl.opCode = 6'd0;
    ctrl.stall  = 1'b0;
    ctrl.flush  = 1'b0;
    rst         = 1'b1;

    // Reset with conflicting inputs must still clear everything.
    apply("reset", 6'd1, 1'b1, 1'b1, 1'b1, 9'b00_00_0000_0);
    apply("reset2", 6'd0, 1'b0, 1'b0, 1'b1, 9'b00_00_0000_0);

    apply("rtype", 6'd0, 1'b0, 1'b0, 1'b0, 9'b10_00_1100_0);
    apply("load",  6'd1, 1'b0, 1'b0, 1'b0, 9'b11_10_0001_0);
    apply("store", 6'd2, 1'b0, 1'b0, 1'b0, 9'b00_01_0001_0);
    apply("branch",6'd3, 1'b0, 1'b0, 1'b0, 9'b00_00_0010_0);
    apply("addi",  6'd4, 1'b0, 1'b0, 1'b0, 9'b10_00_0001_0);
    apply("logi",  6'd5, 1'b0, 1'b0, 1'b0, 9'b10_00_0111_0);
    apply("op63",  6'd63,1'b0, 1'b0, 1'b0, 9'b00_00_0000_1);
    apply("op6",   6'd6, 1'b0, 1'b0, 1'b0, 9'b00_00_0000_1);

    // Stall holds a load while a store waits on the opcode bus.
    apply("preStall", 6'd1, 1'b0, 1'b0, 1'b0, 9'b11_10_0001_0);
    apply("stall1",   6'd2, 1'b1, 1'b0, 1'b0, 9'b11_10_0001_0);
    apply("stall2",   6'd2, 1'b1, 1'b0, 1'b0, 9'b11_10_0001_0);
    apply("stall3",   6'd2, 1'b1, 1'b0, 1'b0, 9'b11_10_0001_0);
    apply("unstall",  6'd2, 1'b0, 1'b0, 1'b0, 9'b00_01_0001_0);

    // Stall holding an illegal flag, then flush must clear illegalOp too.
    apply("illHold0", 6'd40, 1'b0, 1'b0, 1'b0, 9'b00_00_0000_1);
    apply("illHold1", 6'd0,  1'b1, 1'b0, 1'b0, 9'b00_00_0000_1);
    apply("flushIll", 6'd50, 1'b0, 1'b1, 1'b0, 9'b00_00_0000_0);

    // Flush beats stall.
    apply("preFlush",   6'd4, 1'b0, 1'b0, 1'b0, 9'b10_00_0001_0);
    apply("flushStall", 6'd0, 1'b1, 1'b1, 1'b0, 9'b00_00_0000_0);
    apply("postFlush",  6'd0, 1'b0, 1'b0, 1'b0, 9'b10_00_1100_0);

    // Reset during stall.
    apply("rstStall",  6'd1, 1'b1, 1'b0, 1'b1, 9'b00_00_0000_0);
    apply("postRst",   6'd1, 1'b0, 1'b0, 1'b0, 9'b11_10_0001_0);

    // Sweep every opcode with random stall/flush against the reference model.
    model = 9'b11_10_0001_0;
    for (int op = 0; op < 64; op++) begin
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      if (fl)       model = 9'b0;
      else if (!st) model = decodeRef(op[5:0]);
      apply($sformatf("sweep%0d", op), op[5:0], st, fl, 1'b0, model);
      obs = observedVec();
      check("invMem", {8'b0, obs[6] & obs[5]}, 9'b0);
      check("invWr",  {8'b0, obs[8] & obs[5]}, 9'b0);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 The module SHALL have one clock and synchronous, active-high reset; the clock is clk and the reset is rst.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 opCode  input  6  instruction opcode from decode stage.
REQ-005 stall  input  1  when high, registered outputs hold their current value.
REQ-006 flush  input  1  when high, a bubble (all-zero controls) is registered.
REQ-007 writeBackControl  output  2  bit1 = RegWrite, bit0 = MemToReg.
REQ-008 memAccessControl  output  2  bit1 = MemRead, bit0 = MemWrite.
REQ-009 calculationControl  output  4  bit3 = RegDst, bits2:1 = ALUOp, bit0 = ALUSrc.
REQ-010 illegalOp  output  1  high when the registered opcode is undefined.

Function
REQ-011 All outputs SHALL be registered: decode of opCode sampled at rising edge N appears on outputs after edge N, 1-cycle latency, no combinational input-to-output path.
REQ-012 Decode table, as WB / MEM / CALC / illegalOp:
- opCode 0 (R-type): 10 / 00 / 1100 / 0.
- opCode 1 (load): 11 / 10 / 0001 / 0.
- opCode 2 (store): 00 / 01 / 0001 / 0.
- opCode 3 (branch): 00 / 00 / 0010 / 0.
- opCode 4 (add-immediate): 10 / 00 / 0001 / 0.
- opCode 5 (logic-immediate): 10 / 00 / 0111 / 0.
REQ-013 opCode 6..63 SHALL decode to WB=00, MEM=00, CALC=0000, illegalOp=1 (no architectural side effects).
REQ-014 MemRead and MemWrite SHALL never both be 1; RegWrite SHALL be 0 whenever MemWrite is 1.
REQ-015 Priority at each rising edge: rst, then flush, then stall, then normal decode.
REQ-016 flush=1 (rst=0) SHALL register all outputs as 0, including illegalOp=0, regardless of stall.
REQ-017 stall=1 (rst=0, flush=0) SHALL hold all outputs unchanged; opCode is ignored that cycle.
REQ-018 After stall deasserts, outputs SHALL reflect the opCode present at the first non-stalled edge.
REQ-019 The module SHALL contain no state other than the output registers.
REQ-020 X/undriven opCode bits SHALL NOT be relied on; each opCode value SHALL decode deterministically per REQ-012/013.

Reset
REQ-021 rst=1 at a rising edge SHALL set writeBackControl=00, memAccessControl=00, calculationControl=0000, illegalOp=0, overriding flush, stall and opCode.
REQ-022 rst asserted mid-sequence (including during stall) SHALL take effect at the next edge; the first decode after release uses the opCode at the first edge with rst=0.
REQ-023 Before the first reset edge, output values are undefined and SHALL NOT be checked.

Verification
REQ-024 Reset, then opCode 0,1,2,3 on successive edges -> outputs one cycle later: (10,00,1100), (11,10,0001), (00,01,0001), (00,00,0010), illegalOp=0 throughout.
REQ-025 opCode=4 then 5 then 63 -> (10,00,0001,0), (10,00,0111,0), (00,00,0000,1).
REQ-026 opCode=1 registered, then stall=1 for 3 cycles while opCode=2 -> outputs stay (11,10,0001); stall=0 -> next edge (00,01,0001).
REQ-027 opCode=0 with flush=1 and stall=1 together -> all outputs 0 after the edge; flush=0, stall=0 -> (10,00,1100).
REQ-028 opCode=1 with rst=1, flush=0, stall=1 -> all outputs 0 after the edge; rst=0 -> (11,10,0001) one edge later.
REQ-029 Sweep all 64 opCodes with random stall/flush -> every cycle matches a reference model of REQ-012..017, and REQ-014 invariants hold.
